// File: rtl/uart_cmd_link.sv
// uart_cmd_link: assembles opcode+payload frames from the UART receiver
// and paces queued response bytes into the UART transmitter.
module uart_cmd_link #(
   parameter int unsigned DATA_BYTES  = 2,
   parameter int unsigned MSB_FIRST   = 0,
   parameter int unsigned TIMEOUT_CYC = 1000000,
   parameter int unsigned RESP_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              rx_data,
   input  logic                    rx_rdy,
   output logic                    clr_rx_rdy,
   output logic [7:0]              cmd,
   output logic [8*DATA_BYTES-1:0] data,
   output logic                    cmd_rdy,
   input  logic                    clr_cmd_rdy,
   output logic                    frame_err,
   output logic                    overrun,
   input  logic [7:0]              resp,
   input  logic                    send_resp,
   output logic                    resp_full,
   output logic [7:0]              tx_data,
   output logic                    trmt,
   input  logic                    tx_done,
   output logic                    resp_sent
);

   localparam int unsigned DW = 8 * DATA_BYTES;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned AW = $clog2(RESP_DEPTH);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PAYLOAD = 1'b1;

   localparam logic [TW-1:0] T_LAST =
      TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [1:0]    I_LAST = 2'(DATA_BYTES - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(RESP_DEPTH);

   logic [0:0]    state;
   logic [1:0]    idx;
   logic [TW-1:0] tcnt;
   logic [7:0]    sh_cmd;
   logic [DW-1:0] sh_data;
   logic [DW-1:0] nxt_data;
   logic          in_pay;
   logic          timeout;
   logic          done;

   assign clr_rx_rdy = rx_rdy;
   assign in_pay     = (state == S_PAYLOAD);
   assign timeout    = (TIMEOUT_CYC != 0) && in_pay && (tcnt == T_LAST);
   assign done       = rx_rdy && in_pay && !timeout && (idx == I_LAST);
   assign frame_err  = timeout;

   // shadow payload with the incoming byte dropped into its slot
   always_comb begin
      nxt_data = sh_data;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (idx == 2'(i)) begin
            nxt_data[8*((MSB_FIRST != 0) ? DATA_BYTES-1-i : i) +: 8] = rx_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         tcnt    <= '0;
         sh_cmd  <= '0;
         sh_data <= '0;
      end else if (rx_rdy && (!in_pay || timeout)) begin
         state  <= S_PAYLOAD;
         idx    <= '0;
         tcnt   <= '0;
         sh_cmd <= rx_data;
      end else if (rx_rdy) begin
         sh_data <= nxt_data;
         tcnt    <= '0;
         if (idx == I_LAST) begin
            state <= S_IDLE;
         end else begin
            idx <= idx + 2'd1;
         end
      end else if (timeout) begin
         state <= S_IDLE;
         tcnt  <= '0;
      end else if (in_pay && (TIMEOUT_CYC != 0)) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd     <= '0;
         data    <= '0;
         cmd_rdy <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= done && cmd_rdy && !clr_cmd_rdy;
         if (done) begin
            cmd     <= sh_cmd;
            data    <= nxt_data;
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   logic [7:0]    mem [RESP_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          tx_busy;
   logic          push;
   logic          empty;

   assign empty     = (cnt == '0);
   assign resp_full = (cnt == FULL_CNT);
   assign push      = send_resp && !resp_full;
   assign trmt      = !empty && !tx_busy;
   assign tx_data   = empty ? 8'h00 : mem[rp];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= resp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         resp_sent <= tx_done;
         if (push) begin
            wp <= wp + 1'b1;
         end
         if (trmt) begin
            rp <= rp + 1'b1;
         end
         unique case ({push, trmt})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (trmt) begin
            tx_busy <= 1'b1;
         end else if (tx_done) begin
            tx_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_link.sv
// Self-checking bench for uart_cmd_link: directed scenarios plus
// randomized frames and response traffic against a behavioural model.
module tb_uart_cmd_link;

   localparam int DB  = 2;
   localparam int DB2 = 3;
   localparam int TO  = 50;
   localparam int DEP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  rx_data = '0;
   logic        rx_rdy = 1'b0;
   logic        clr_rx_rdy;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic        frame_err;
   logic        overrun;
   logic [7:0]  resp = '0;
   logic        send_resp = 1'b0;
   logic        resp_full;
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done = 1'b0;
   logic        resp_sent;

   logic [7:0]  rx_data2 = '0;
   logic        rx_rdy2 = 1'b0;
   logic        clr_rx_rdy2;
   logic [7:0]  cmd2;
   logic [23:0] data2;
   logic        cmd_rdy2;
   logic        clr_cmd_rdy2 = 1'b0;
   logic        frame_err2;
   logic        overrun2;
   logic        resp_full2;
   logic [7:0]  tx_data2;
   logic        trmt2;
   logic        resp_sent2;

   uart_cmd_link #(
      .DATA_BYTES(DB), .MSB_FIRST(1), .TIMEOUT_CYC(TO), .RESP_DEPTH(DEP)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
      .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err), .overrun(overrun),
      .resp(resp), .send_resp(send_resp), .resp_full(resp_full),
      .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
      .resp_sent(resp_sent)
   );

   uart_cmd_link #(
      .DATA_BYTES(DB2), .MSB_FIRST(0), .TIMEOUT_CYC(0), .RESP_DEPTH(2)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data2), .rx_rdy(rx_rdy2),
      .clr_rx_rdy(clr_rx_rdy2), .cmd(cmd2), .data(data2),
      .cmd_rdy(cmd_rdy2), .clr_cmd_rdy(clr_cmd_rdy2),
      .frame_err(frame_err2), .overrun(overrun2), .resp(8'h00),
      .send_resp(1'b0), .resp_full(resp_full2), .tx_data(tx_data2),
      .trmt(trmt2), .tx_done(1'b0), .resp_sent(resp_sent2)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_cmd;
   logic [15:0] exp_data;
   logic        exp_rdy;
   logic        exp_ovr;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic clr);
      rx_data = b;
      rx_rdy = 1'b1;
      clr_cmd_rdy = clr;
      step();
      rx_rdy = 1'b0;
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic send2(input logic [7:0] b, input logic clr);
      rx_data2 = b;
      rx_rdy2 = 1'b1;
      clr_cmd_rdy2 = clr;
      step();
      rx_rdy2 = 1'b0;
      clr_cmd_rdy2 = 1'b0;
   endtask

   // sends one frame and advances the expected held-frame state
   task automatic frame1(input logic [7:0] c, input logic [7:0] p0,
                         input logic [7:0] p1, input logic clr_last,
                         input int gap);
      send(c, 1'b0);
      repeat (gap) step();
      send(p0, 1'b0);
      repeat (gap) step();
      send(p1, clr_last);
      exp_ovr  = exp_rdy && !clr_last;
      exp_rdy  = 1'b1;
      exp_cmd  = c;
      exp_data = 16'(int'(p0) * 256 + int'(p1));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      rx_rdy = 1'b1;
      #1;
      checks++; if (clr_rx_rdy !== 1'b1) begin errors++; $display("FAIL rst clr_rx_rdy got %b want 1", clr_rx_rdy); end
      rx_rdy = 1'b0;
      #1;
      checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL rst clr_rx_rdy_lo got %b want 0", clr_rx_rdy); end
      checks++; if (cmd !== 8'h00 || data !== 16'h0000) begin errors++; $display("FAIL rst cmd/data got %h/%h want 00/0000", cmd, data); end
      checks++; if ({cmd_rdy, frame_err, overrun} !== 3'b000) begin errors++; $display("FAIL rst rx flags got %b want 000", {cmd_rdy, frame_err, overrun}); end
      checks++; if ({resp_full, trmt, resp_sent} !== 3'b000) begin errors++; $display("FAIL rst tx flags got %b want 000", {resp_full, trmt, resp_sent}); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst tx_data got %h want 00", tx_data); end
      checks++; if (cmd2 !== 8'h00 || data2 !== 24'h0 || cmd_rdy2 !== 1'b0) begin errors++; $display("FAIL rst dut2 got %h/%h/%b want 0", cmd2, data2, cmd_rdy2); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      exp_cmd = 8'h00; exp_data = 16'h0; exp_rdy = 1'b0; exp_ovr = 1'b0;
   endtask

   task automatic test_frame();
      send(8'hA5, 1'b0);
      send(8'h12, 1'b0);
      checks++; if (cmd_rdy !== 1'b0 || cmd !== 8'h00) begin errors++; $display("FAIL partial cmd_rdy/cmd got %b/%h want 0/00", cmd_rdy, cmd); end
      send(8'h34, 1'b0);
      checks++; if (cmd !== 8'hA5) begin errors++; $display("FAIL frame cmd got %h want a5", cmd); end
      checks++; if (data !== 16'h1234) begin errors++; $display("FAIL frame data got %h want 1234", data); end
      checks++; if (cmd_rdy !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL frame rdy/ovr got %b/%b want 1/0", cmd_rdy, overrun); end
      clr_cmd_rdy = 1'b1;
      step();
      clr_cmd_rdy = 1'b0;
      checks++; if (cmd_rdy !== 1'b0 || cmd !== 8'hA5) begin errors++; $display("FAIL clr cmd_rdy/cmd got %b/%h want 0/a5", cmd_rdy, cmd); end
      exp_cmd = 8'hA5; exp_data = 16'h1234; exp_rdy = 1'b0;
   endtask

   task automatic test_timeout();
      int first;
      int highs;
      first = -1;
      highs = 0;
      send(8'h02, 1'b0);
      send(8'h11, 1'b0);
      for (int k = 1; k <= 60; k++) begin
         if (frame_err === 1'b1) begin
            highs++;
            if (first < 0) first = k;
         end
         step();
      end
      checks++; if (first != TO) begin errors++; $display("FAIL timeout first_cycle got %0d want %0d", first, TO); end
      checks++; if (highs != 1) begin errors++; $display("FAIL timeout pulse_len got %0d want 1", highs); end
      checks++; if (cmd !== exp_cmd || data !== exp_data || cmd_rdy !== exp_rdy) begin errors++; $display("FAIL timeout held got %h/%h/%b want %h/%h/%b", cmd, data, cmd_rdy, exp_cmd, exp_data, exp_rdy); end
      frame1(8'h03, 8'h44, 8'h55, 1'b0, 0);
      checks++; if (cmd !== 8'h03 || data !== 16'h4455 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL after_to frame got %h/%h/%b want 03/4455/1", cmd, data, cmd_rdy); end
      // a byte landing exactly in the timeout cycle starts a new frame
      send(8'h02, 1'b0);
      send(8'h11, 1'b0);
      repeat (TO - 1) step();
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL to_cycle frame_err got %b want 1", frame_err); end
      frame1(8'h06, 8'h77, 8'h88, 1'b1, 0);
      checks++; if (cmd !== 8'h06 || data !== 16'h7788) begin errors++; $display("FAIL to_opcode got %h/%h want 06/7788", cmd, data); end
      checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL to_opcode ovr/err got %b/%b want 0/0", overrun, frame_err); end
   endtask

   task automatic test_overrun();
      frame1(8'h07, 8'h88, 8'h99, 1'b0, 1);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun pulse got %b want 1", overrun); end
      checks++; if (cmd !== 8'h07 || data !== 16'h8899) begin errors++; $display("FAIL overrun frame got %h/%h want 07/8899", cmd, data); end
      step();
      checks++; if (overrun !== 1'b0 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL overrun after got %b/%b want 0/1", overrun, cmd_rdy); end
      frame1(8'h08, 8'hAB, 8'hCD, 1'b1, 0);
      checks++; if (cmd_rdy !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL coincident rdy/ovr got %b/%b want 1/0", cmd_rdy, overrun); end
   endtask

   task automatic test_random_frames();
      logic [7:0] c, p0, p1;
      int mode;
      for (int n = 0; n < 30; n++) begin
         c = 8'($urandom);
         p0 = 8'($urandom);
         p1 = 8'($urandom);
         mode = int'($urandom_range(0, 2));
         if (mode == 2) begin
            clr_cmd_rdy = 1'b1;
            step();
            clr_cmd_rdy = 1'b0;
            exp_rdy = 1'b0;
            checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL rnd clr got %b want 0", cmd_rdy); end
         end
         frame1(c, p0, p1, mode == 1, int'($urandom_range(0, 10)));
         checks++; if (cmd !== exp_cmd || data !== exp_data) begin errors++; $display("FAIL rnd frame %0d got %h/%h want %h/%h", n, cmd, data, exp_cmd, exp_data); end
         checks++; if (cmd_rdy !== exp_rdy || overrun !== exp_ovr) begin errors++; $display("FAIL rnd flags %0d got %b/%b want %b/%b", n, cmd_rdy, overrun, exp_rdy, exp_ovr); end
      end
   endtask

   task automatic test_order();
      logic [7:0] b0, b1, b2;
      logic [23:0] e;
      int errs;
      errs = 0;
      send2(8'h01, 1'b0);
      send2(8'hAA, 1'b0);
      send2(8'hBB, 1'b0);
      for (int k = 0; k < 100; k++) begin
         if (frame_err2 !== 1'b0) errs++;
         step();
      end
      checks++; if (errs != 0) begin errors++; $display("FAIL no_timeout frame_err2 got %0d pulses want 0", errs); end
      send2(8'hCC, 1'b0);
      checks++; if (cmd2 !== 8'h01 || data2 !== 24'hCCBBAA) begin errors++; $display("FAIL order got %h/%h want 01/ccbbaa", cmd2, data2); end
      checks++; if (cmd_rdy2 !== 1'b1) begin errors++; $display("FAIL order cmd_rdy2 got %b want 1", cmd_rdy2); end
      for (int n = 0; n < 8; n++) begin
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         b2 = 8'($urandom);
         send2(8'(n), 1'b0);
         send2(b0, 1'b0);
         send2(b1, 1'b0);
         send2(b2, 1'b1);
         e = 24'(int'(b0) + int'(b1) * 256 + int'(b2) * 65536);
         checks++; if (data2 !== e || cmd2 !== 8'(n)) begin errors++; $display("FAIL order rnd %0d got %h/%h want %h/%h", n, cmd2, data2, 8'(n), e); end
         checks++; if (overrun2 !== 1'b0 || cmd_rdy2 !== 1'b1) begin errors++; $display("FAIL order rnd flags %0d got %b/%b want 0/1", n, overrun2, cmd_rdy2); end
      end
   endtask

   task automatic test_tx_queue();
      logic [7:0] v [5];
      v[0] = 8'hA5; v[1] = 8'h5A; v[2] = 8'h01; v[3] = 8'h02; v[4] = 8'h03;
      resp = 8'h77;
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
      checks++; if (trmt !== 1'b1 || tx_data !== 8'h77) begin errors++; $display("FAIL tx first got %b/%h want 1/77", trmt, tx_data); end
      step();
      checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL tx one_shot got %b want 0", trmt); end
      for (int i = 0; i < 5; i++) begin
         resp = v[i];
         send_resp = 1'b1;
         step();
         checks++; if (resp_full !== (i >= 3) || trmt !== 1'b0) begin errors++; $display("FAIL tx push %0d full/trmt got %b/%b want %b/0", i, resp_full, trmt, i >= 3); end
      end
      send_resp = 1'b0;
      for (int j = 0; j < 4; j++) begin
         tx_done = 1'b1;
         step();
         tx_done = 1'b0;
         checks++; if (resp_sent !== 1'b1) begin errors++; $display("FAIL tx resp_sent %0d got %b want 1", j, resp_sent); end
         checks++; if (trmt !== 1'b1 || tx_data !== v[j]) begin errors++; $display("FAIL tx order %0d got %b/%h want 1/%h", j, trmt, tx_data, v[j]); end
         step();
         checks++; if (trmt !== 1'b0 || resp_full !== 1'b0) begin errors++; $display("FAIL tx gap %0d got %b/%b want 0/0", j, trmt, resp_full); end
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      step();
      checks++; if (trmt !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL tx dropped got %b/%h want 0/00", trmt, tx_data); end
   endtask

   task automatic test_tx_random();
      logic [7:0] q[$];
      logic busy_m;
      logic prev_done;
      logic e_trmt;
      busy_m = 1'b0;
      prev_done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         send_resp = (c < 300) && ($urandom_range(0, 1) == 1);
         resp = 8'($urandom);
         tx_done = busy_m && ((c >= 300) || ($urandom_range(0, 3) == 0));
         e_trmt = (q.size() > 0) && !busy_m;
         checks++; if (trmt !== e_trmt) begin errors++; $display("FAIL txr trmt c%0d got %b want %b", c, trmt, e_trmt); end
         if (e_trmt) begin
            checks++; if (tx_data !== q[0]) begin errors++; $display("FAIL txr data c%0d got %h want %h", c, tx_data, q[0]); end
         end
         checks++; if (resp_full !== (q.size() == DEP)) begin errors++; $display("FAIL txr full c%0d got %b want %b", c, resp_full, q.size() == DEP); end
         checks++; if (resp_sent !== prev_done) begin errors++; $display("FAIL txr sent c%0d got %b want %b", c, resp_sent, prev_done); end
         if (send_resp && q.size() < DEP) q.push_back(resp);
         if (e_trmt) void'(q.pop_front());
         busy_m = e_trmt ? 1'b1 : (tx_done ? 1'b0 : busy_m);
         prev_done = tx_done;
         step();
      end
      send_resp = 1'b0;
      tx_done = 1'b0;
   endtask

   task automatic test_reset_mid();
      resp = 8'h11; send_resp = 1'b1; step();
      resp = 8'h22; step();
      resp = 8'h33; step();
      send_resp = 1'b0;
      send(8'h0A, 1'b0);
      send(8'h0B, 1'b0);
      rst_n = 1'b0;
      #1;
      checks++; if (cmd !== 8'h00 || data !== 16'h0 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst rx got %h/%h/%b want 0", cmd, data, cmd_rdy); end
      checks++; if ({resp_full, trmt, tx_data} !== 10'h000) begin errors++; $display("FAIL mid_rst tx got %b/%b/%h want 0", resp_full, trmt, tx_data); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      exp_rdy = 1'b0;
      send(8'hEE, 1'b0);
      checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst stale_frame got %b want 0", cmd_rdy); end
      step();
      // 0xEE opened a fresh frame; it is completed here
      send(8'hDE, 1'b0);
      send(8'hAD, 1'b0);
      checks++; if (cmd !== 8'hEE || data !== 16'hDEAD || cmd_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst frame got %h/%h/%b want ee/dead/1", cmd, data, cmd_rdy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst ovr got %b want 0", overrun); end
      for (int k = 0; k < 20; k++) begin
         checks++; if (trmt !== 1'b0) begin errors++; $display("FAIL mid_rst stale_tx k%0d got %b want 0", k, trmt); end
         step();
      end
      resp = 8'h3C;
      send_resp = 1'b1;
      step();
      send_resp = 1'b0;
      checks++; if (trmt !== 1'b1 || tx_data !== 8'h3C) begin errors++; $display("FAIL mid_rst tx_after got %b/%h want 1/3c", trmt, tx_data); end
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_frame();
      test_timeout();
      test_overrun();
      test_random_frames();
      test_order();
      test_tx_queue();
      test_tx_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_cmd_link.md
# uart_cmd_link

Parametrised command/response link between the byte-level UART transceiver and the command processor. On receive it assembles an opcode byte plus DATA_BYTES payload bytes into a held command word, with inter-byte timeout and overrun detection. On transmit it buffers response bytes in a RESP_DEPTH FIFO and paces them into the UART one at a time.

## Interface
- DATA_BYTES, 2: payload bytes per frame after the opcode; legal 1..4.
- MSB_FIRST, 0: 1 = first payload byte is most significant; 0 = first payload byte is least significant.
- TIMEOUT_CYC, 1000000: max idle cycles between bytes of one frame; 0 disables timeout.
- RESP_DEPTH, 4: response FIFO depth; power of 2, at least 2.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  byte from UART
- rx_rdy  in  1  UART byte valid (level)
- clr_rx_rdy  out  1  combinational; equals rx_rdy (byte consumed this cycle)
- cmd  out  8  opcode of last completed frame
- data  out  8*DATA_BYTES  payload of last completed frame
- cmd_rdy  out  1  completed frame waiting
- clr_cmd_rdy  in  1  host has consumed the frame
- frame_err  out  1  1-cycle pulse: partial frame discarded on timeout
- overrun  out  1  1-cycle pulse: frame completed while cmd_rdy still set
- resp  in  8  response byte
- send_resp  in  1  push resp into FIFO
- resp_full  out  1  FIFO full
- tx_data  out  8  FIFO head to UART; 0 when FIFO empty
- trmt  out  1  start UART transmit
- tx_done  in  1  UART transmit complete pulse
- resp_sent  out  1  1-cycle pulse, registered copy of tx_done

## Operation
- RX FSM states:
  - IDLE: accepts opcode into shadow register; byte index := 0; go to PAYLOAD.
  - PAYLOAD: each accepted byte is stored at its index. The final byte (index DATA_BYTES-1) completes the frame and returns to IDLE.
- Byte accepted in any cycle rx_rdy=1. No edge detection; the UART drops rx_rdy after clr_rx_rdy.
- Assembly happens in shadow registers. cmd/data update only on frame completion, so a partial frame never disturbs the held outputs.
- Byte order:
  - MSB_FIRST=1: data = {b0, b1, ...}.
  - MSB_FIRST=0: data = {..., b1, b0}.
- cmd_rdy priority, high to low: frame completion sets (wins over simultaneous clr_cmd_rdy, no overrun); clr_cmd_rdy clears; otherwise hold.
- overrun pulses when a frame completes with cmd_rdy=1 and clr_cmd_rdy=0. New cmd/data overwrite the held frame.
- Timeout counter:
  - Clears on every accepted byte.
  - Counts only in PAYLOAD.
  - At TIMEOUT_CYC: FSM to IDLE, frame_err pulses, cmd/data/cmd_rdy unchanged.
  - A byte arriving in the timeout cycle is treated as a new opcode.
- TX FIFO:
  - Push when send_resp=1 and resp_full=0. Push while full is dropped; full is evaluated before any same-cycle pop.
  - trmt = FIFO non-empty and not tx_busy. The pop occurs in the trmt cycle.
  - tx_busy is set the cycle after trmt and cleared in the tx_done cycle.
  - Simultaneous push and pop with FIFO not full: count unchanged, both take effect.
  - Pointers wrap modulo RESP_DEPTH; the count has one extra bit to distinguish full from empty.

## Timing
- Reset: state IDLE; counters, shadows and FIFO cleared. cmd=0, data=0, cmd_rdy=0, frame_err=0, overrun=0, resp_full=0, tx_data=0, trmt=0, resp_sent=0; clr_rx_rdy follows rx_rdy.
- Reset mid-frame or mid-transmit discards the partial frame and all queued responses. tx_busy clears.
- Final byte accepted in cycle N: cmd/data/cmd_rdy/overrun valid at N+1.
- Timeout: byte at cycle N, none after; frame_err high at N+TIMEOUT_CYC.
- Push into empty FIFO with tx idle at cycle N: trmt=1 with tx_data valid at N+1 for exactly one cycle.
- tx_done at cycle M: resp_sent at M+1. Next trmt no earlier than M+1.
- resp_full asserts the cycle after the push that fills the FIFO.

## Test plan
- Frame in, MSB_FIRST=1, DATA_BYTES=2: bytes 0xA5, 0x12, 0x34 -> cmd=0xA5, data=0x1234, cmd_rdy=1 one cycle after last byte. clr_cmd_rdy -> cmd_rdy=0.
- Byte order, MSB_FIRST=0, DATA_BYTES=3: 0x01, 0xAA, 0xBB, 0xCC -> data=0xCCBBAA.
- Timeout, TIMEOUT_CYC=50: 0x02, 0x11, then 50 idle cycles -> frame_err pulse, prior cmd/data held. Then 0x03, 0x44, 0x55 -> cmd=0x03, data=0x4455.
- Overrun: two complete frames without clr_cmd_rdy -> overrun pulse, second frame's values held. Completion coincident with clr_cmd_rdy -> cmd_rdy stays 1, no overrun.
- TX queue, RESP_DEPTH=4: push 0xA5, 0x5A, 0x01, 0x02, 0x03 back-to-back, UART busy -> resp_full set, 0x03 dropped. trmt issues 0xA5, 0x5A, 0x01, 0x02 in order, one per tx_done.
- Reset after 2 of 3 bytes and with FIFO holding 2 entries -> all outputs at reset values. A following clean frame decodes correctly and no stale bytes are transmitted.
